mod5_check_scheduler: RTL and testbench
=======================================

# mod5_check_scheduler

Time-shares one serial divisible-by-5 checker between N_REQ requesters. Each requester submits a W-bit word over a valid/ready handshake. A round-robin arbiter grants one requester, and the controller then clears the checker, streams the word into it MSB-first, samples its verdict and returns the verdict with the requester ID. Only one job is outstanding at a time. The block sits between the requester ports and the checker's clk/resetn/din/dout pins.

## Interface
- N_REQ, 4, number of requesters (≥2)
- W, 8, word width in bits (≥1)
- ID_W, $clog2(N_REQ), requester ID width (derived, not overridden)

- clk  in  1  rising-edge clock shared with the checker
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  bit i: requester i presents a word
- req_data  in  N_REQ*W  word i is at bits [i*W +: W]
- req_ready  out  N_REQ  one-hot grant; transfer on req_valid[i] & req_ready[i]
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  ID_W  index of the requester that owns the result
- resp_div  out  1  1 = word is divisible by 5
- busy  out  1  state ≠ IDLE
- chk_resetn  out  1  drives the checker's resetn
- chk_din  out  1  drives the checker's din
- chk_dout  in  1  checker's dout, where 1 = remainder 0

## Operation
- **States:** IDLE → CLR → SETTLE → SHIFT → SAMPLE → RESP → IDLE.
- **IDLE**
  - Arbiter picks the first i with req_valid[i] set, searching from (last_grant+1) mod N_REQ upward with wrap.
  - req_ready = that one-hot grant. req_ready is combinational but gated to 0 while resetn is low and outside IDLE.
  - On handshake: latch word → shift register, i → id register, last_grant ← i, go to CLR.
- **CLR** (1 cycle): chk_resetn=0, chk_din=0.
- **SETTLE** (1 cycle): chk_resetn=1, chk_din=0.
- **SHIFT** (W cycles)
  - chk_din = shift_reg[W-1]; shift left each cycle.
  - Bit counter runs 0..W-1; leave SHIFT after count W-1.
- **SAMPLE** (1 cycle): chk_din=0; capture chk_dout into the resp_div register at the end of the cycle.
- **RESP**
  - resp_valid=1; resp_id and resp_div are held stable.
  - On resp_valid & resp_ready, go to IDLE. The next request cannot be accepted in that same cycle.
- **Outside SHIFT:** chk_din=0. **Outside CLR and reset:** chk_resetn=1.
- **Arithmetic:** word value 0 → resp_div=1. All words are unsigned W-bit values.
- **Requests outside IDLE:** ignored; the requester must hold req_valid and its data until it sees req_ready.
- **Reset** (async, any state, including mid-SHIFT or RESP):
  - state=IDLE, last_grant=N_REQ-1 (so requester 0 has top priority first).
  - resp_valid=0, resp_id=0, resp_div=0, busy=0.
  - chk_resetn=0 while resetn is low; chk_din=0; req_ready=0.
  - An in-flight job is dropped silently.

## Timing
- **Accept:** at the rising edge E0 where the IDLE handshake occurs.
- **Checker clear:** chk_resetn is low for exactly the cycle between E0 and E1.
- **Bit stream:** data bit W-1-k is on chk_din during the cycle ending at edge E(3+k), for k=0..W-1. The MSB is therefore consumed at E3 and the LSB at E(W+2).
- **Sample:** chk_dout is captured at E(W+3).
- **Result:** resp_valid goes high immediately after E(W+3), i.e. W+3 edges after the accept edge.
- **Minimum job spacing:** W+5 cycles per job with resp_ready held high (accept cycle plus RESP cycle included).
- **Back-pressure:** while resp_ready=0, stay in RESP indefinitely with all outputs constant and req_ready all 0.
- **Grant rule:** last_grant updates only on an accepted handshake.

## Test plan
- **Single request (W=8):** req0 presents 8'd5.
  - chk_din over E3..E10 = 0,0,0,0,0,1,0,1.
  - resp_valid at E11; resp_id=0, resp_div=1; chk_resetn low only for E0→E1.
- **Non-divisible word:** req1 alone presents 8'd6 → resp_id=1, resp_div=0. A following 8'd0 → resp_div=1.
- **Simultaneous requests:** all four valid at once with data 10, 11, 0, 255 and resp_ready=1.
  - Service order is 0, 1, 2, 3; resp_div = 1, 0, 1, 1.
  - Consecutive accepts are 13 cycles apart.
- **Fairness:** req0 and req2 are held valid continuously → grant order 0, 2, 0, 2, …; requesters 1 and 3 never receive req_ready.
- **Back-pressure:** hold resp_ready=0 for 5 cycles during RESP → resp_valid, resp_id and resp_div stay stable, req_ready=0, busy=1. Return to IDLE one edge after resp_ready rises.
- **Reset mid-SHIFT:** assert resetn low after the 4th bit edge.
  - Immediately: resp_valid=0, busy=0, chk_resetn=0.
  - After release, with req0 and req3 valid, req0 is granted first and produces a correct full result.

Source files
------------

// File: rtl/mod5_check_scheduler.sv
// Round-robin scheduler that time-shares one serial divisible-by-5 checker
// between N_REQ requesters, with a single job in flight at a time.
module mod5_check_scheduler #(
  parameter  int N_REQ = 4,
  parameter  int W     = 8,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output logic               resp_div,
  output logic               busy,
  output logic               chk_resetn,
  output logic               chk_din,
  input  logic               chk_dout
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {IDLE, CLR, SETTLE, SHIFT, SAMPLE, RESP} state_t;

  state_t           state;
  logic [W-1:0]     shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [ID_W-1:0]  last_grant;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic [W-1:0]     grant_word;
  logic             grant_any;

  // Two passes give the wrap-around search: first above last_grant, then from 0.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    grant_word = '0;
    grant_any  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any && i > int'(last_grant) && req_valid[i]) begin
        grant_any  = 1'b1;
        grant[i]   = 1'b1;
        grant_idx  = ID_W'(i);
        grant_word = req_data[i*W +: W];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_any && i <= int'(last_grant) && req_valid[i]) begin
        grant_any  = 1'b1;
        grant[i]   = 1'b1;
        grant_idx  = ID_W'(i);
        grant_word = req_data[i*W +: W];
      end
    end
  end

  assign req_ready  = (resetn && state == IDLE) ? grant : '0;
  assign chk_resetn = resetn && (state != CLR);
  assign chk_din    = (state == SHIFT) && shift_reg[W-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      shift_reg  <= '0;
      bit_cnt    <= '0;
      resp_id    <= '0;
      resp_div   <= 1'b0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            shift_reg  <= grant_word;
            resp_id    <= grant_idx;
            last_grant <= grant_idx;
            busy       <= 1'b1;
            state      <= CLR;
          end
        end
        CLR: state <= SETTLE;
        SETTLE: begin
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          shift_reg <= shift_reg << 1;
          if (bit_cnt == CNT_W'(W - 1)) begin
            state <= SAMPLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        // The checker has consumed the LSB at the previous edge, so dout is final here.
        SAMPLE: begin
          resp_div   <= chk_dout;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod5_check_scheduler.sv
// Bench for mod5_check_scheduler: directed scenarios plus random traffic,
// checked cycle by cycle against a job-level reference model.
module tb_mod5_check_scheduler;

  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int ID_W  = $clog2(N_REQ);

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [N_REQ*W-1:0] req_data = '0;
  logic [N_REQ-1:0]   req_ready;
  logic               resp_valid;
  logic               resp_ready = 1'b1;
  logic [ID_W-1:0]    resp_id;
  logic               resp_div;
  logic               busy;
  logic               chk_resetn;
  logic               chk_din;
  logic               chk_dout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0]     pend[N_REQ][$];
  logic [N_REQ-1:0] hs = '0;

  bit           job_on = 1'b0;
  int           jc = 0;
  int           job_id = 0;
  logic [W-1:0] job_word = '0;
  int           model_last = N_REQ - 1;
  int           resp_count = 0;
  int           grant_log[$];
  int           accept_log[$];
  int           rid_log[$];
  int           rdiv_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod5_check_scheduler #(.N_REQ(N_REQ), .W(W)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_div(resp_div), .busy(busy),
    .chk_resetn(chk_resetn), .chk_din(chk_din), .chk_dout(chk_dout)
  );

  // Serial remainder-mod-5 checker: each din bit appends to the value MSB-first.
  logic [2:0] rem;
  always @(posedge clk or negedge chk_resetn) begin
    if (!chk_resetn) rem <= 3'd0;
    else             rem <= 3'((2 * int'(rem) + int'(chk_din)) % 5);
  end
  assign chk_dout = (rem == 3'd0);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [W-1:0] word);
    pend[idx].push_back(word);
  endtask

  function automatic int getLog(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic clearLogs();
    grant_log.delete();
    accept_log.delete();
    rid_log.delete();
    rdiv_log.delete();
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    clearLogs();
  endtask

  task automatic waitResponses(input int target, input int budget);
    int n;
    n = 0;
    while (resp_count < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("wait_resp", 32'(resp_count >= target), 1);
  endtask

  // Requester side: retire the word that transferred at this edge, present the next.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (hs[i] && pend[i].size() > 0) void'(pend[i].pop_front());
      req_valid[i]       = (pend[i].size() > 0);
      req_data[i*W +: W] = (pend[i].size() > 0) ? pend[i][0] : '0;
    end
  end

  // Job-level model: jc counts cycles since the accept cycle (jc=0 ends at the accept edge).
  always @(negedge clk) begin
    int gi;
    logic [N_REQ-1:0] exp_gnt;
    gi = -1;
    exp_gnt = '0;
    hs = req_valid & req_ready;
    if (!resetn) begin
      job_on = 1'b0;
      model_last = N_REQ - 1;
      checkOutput("rst_req_ready", 32'(req_ready), 0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_chk_resetn", 32'(chk_resetn), 0);
      checkOutput("rst_chk_din", 32'(chk_din), 0);
      checkOutput("rst_resp_id", 32'(resp_id), 0);
      checkOutput("rst_resp_div", 32'(resp_div), 0);
    end else if (!job_on) begin
      for (int k = 1; k <= N_REQ; k++)
        if (gi < 0 && req_valid[(model_last + k) % N_REQ]) gi = (model_last + k) % N_REQ;
      if (gi >= 0) exp_gnt[gi] = 1'b1;
      checkOutput("idle_grant", 32'(req_ready), 32'(exp_gnt));
      checkOutput("idle_busy", 32'(busy), 0);
      checkOutput("idle_resp_valid", 32'(resp_valid), 0);
      checkOutput("idle_chk_resetn", 32'(chk_resetn), 1);
      checkOutput("idle_chk_din", 32'(chk_din), 0);
      if (gi >= 0) begin
        job_on = 1'b1;
        jc = 0;
        job_id = gi;
        job_word = req_data[gi*W +: W];
        model_last = gi;
        grant_log.push_back(gi);
        accept_log.push_back(cyc);
      end
    end else begin
      jc++;
      checkOutput("job_busy", 32'(busy), 1);
      checkOutput("job_req_ready", 32'(req_ready), 0);
      checkOutput("job_chk_resetn", 32'(chk_resetn), (jc == 1) ? 0 : 1);
      if (jc >= 3 && jc <= W + 2)
        checkOutput("job_din_bit", 32'(chk_din), 32'(job_word[W - 1 - (jc - 3)]));
      else
        checkOutput("job_din_zero", 32'(chk_din), 0);
      if (jc <= W + 3) begin
        checkOutput("job_resp_early", 32'(resp_valid), 0);
      end else begin
        checkOutput("resp_valid", 32'(resp_valid), 1);
        checkOutput("resp_id", 32'(resp_id), 32'(job_id));
        checkOutput("resp_div", 32'(resp_div), 32'(job_word % 5 == 0));
        if (resp_ready) begin
          rid_log.push_back(int'(resp_id));
          rdiv_log.push_back(int'(resp_div));
          resp_count++;
          job_on = 1'b0;
        end
      end
    end
  end

  initial begin
    int n, pushes, base;
    bit drained;

    // Reset state and gating: requester 0 is valid while reset is held.
    applyStimulus(0, 8'd5);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    waitResponses(1, 40);
    checkOutput("single_id", getLog(rid_log, 0), 0);
    checkOutput("single_div", getLog(rdiv_log, 0), 1);

    applyReset();
    applyStimulus(1, 8'd6);
    applyStimulus(1, 8'd0);
    waitResponses(resp_count + 2, 60);
    checkOutput("nondiv_id", getLog(rid_log, 0), 1);
    checkOutput("nondiv_div", getLog(rdiv_log, 0), 0);
    checkOutput("zero_id", getLog(rid_log, 1), 1);
    checkOutput("zero_div", getLog(rdiv_log, 1), 1);

    applyReset();
    applyStimulus(0, 8'd10);
    applyStimulus(1, 8'd11);
    applyStimulus(2, 8'd0);
    applyStimulus(3, 8'd255);
    waitResponses(resp_count + 4, 100);
    for (int i = 0; i < 4; i++) checkOutput("simul_order", getLog(rid_log, i), i);
    checkOutput("simul_div0", getLog(rdiv_log, 0), 1);
    checkOutput("simul_div1", getLog(rdiv_log, 1), 0);
    checkOutput("simul_div2", getLog(rdiv_log, 2), 1);
    checkOutput("simul_div3", getLog(rdiv_log, 3), 1);
    for (int i = 1; i < 4; i++)
      checkOutput("simul_spacing", getLog(accept_log, i) - getLog(accept_log, i - 1), W + 5);

    applyReset();
    applyStimulus(0, 8'd20); applyStimulus(0, 8'd21); applyStimulus(0, 8'd22);
    applyStimulus(2, 8'd23); applyStimulus(2, 8'd24); applyStimulus(2, 8'd25);
    waitResponses(resp_count + 6, 150);
    for (int i = 0; i < 6; i++) checkOutput("fair_order", getLog(grant_log, i), (i % 2 == 0) ? 0 : 2);
    checkOutput("fair_div_a", getLog(rdiv_log, 0), 1);
    checkOutput("fair_div_b", getLog(rdiv_log, 5), 1);

    // Back-pressure with a competing request arriving during the stall.
    applyReset();
    resp_ready = 1'b0;
    applyStimulus(2, 8'd15);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 30);
    checkOutput("bp_seen", 32'(resp_valid), 1);
    #1 applyStimulus(0, 8'd7);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(resp_valid), 1);
      checkOutput("bp_id", 32'(resp_id), 2);
      checkOutput("bp_div", 32'(resp_div), 1);
      checkOutput("bp_ready", 32'(req_ready), 0);
      checkOutput("bp_busy", 32'(busy), 1);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_busy", 32'(busy), 0);
    checkOutput("bp_release_valid", 32'(resp_valid), 0);
    waitResponses(resp_count + 1, 40);
    checkOutput("bp_next_id", getLog(rid_log, 1), 0);
    checkOutput("bp_next_div", getLog(rdiv_log, 1), 0);

    // Reset after the fourth bit edge drops the job; priority restarts at 0.
    applyReset();
    applyStimulus(0, 8'd25);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!job_on && n < 20);
    checkOutput("mid_started", 32'(job_on), 1);
    repeat (6) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    checkOutput("mid_resp_valid", 32'(resp_valid), 0);
    checkOutput("mid_busy", 32'(busy), 0);
    checkOutput("mid_chk_resetn", 32'(chk_resetn), 0);
    checkOutput("mid_chk_din", 32'(chk_din), 0);
    applyStimulus(3, 8'd33);
    applyStimulus(0, 8'd35);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    clearLogs();
    waitResponses(resp_count + 2, 60);
    checkOutput("mid_first_id", getLog(rid_log, 0), 0);
    checkOutput("mid_first_div", getLog(rdiv_log, 0), 1);
    checkOutput("mid_second_id", getLog(rid_log, 1), 3);
    checkOutput("mid_second_div", getLog(rdiv_log, 1), 0);

    // Random traffic and random consumer stalls, then drain.
    applyReset();
    base = resp_count;
    pushes = 0;
    for (int c = 0; c < 600; c++) begin
      int idx;
      @(posedge clk);
      #2 resp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, N_REQ - 1);
        if (pend[idx].size() < 3) begin
          applyStimulus(idx, W'($urandom));
          pushes++;
        end
      end
    end
    @(posedge clk);
    #2 resp_ready = 1'b1;
    drained = 1'b0;
    n = 0;
    while (!drained && n < 3000) begin
      @(posedge clk);
      n++;
      drained = !job_on;
      for (int i = 0; i < N_REQ; i++) if (pend[i].size() != 0) drained = 1'b0;
    end
    checkOutput("rand_drained", 32'(drained), 1);
    checkOutput("rand_count", resp_count - base, pushes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
